// File: rtl/gpu_pkg.sv
// Shared types for the draw sequencer: command opcodes, FSM states, queued command layout.
// Pure declarations plus one clipping helper; no logic or state of its own.
package gpu_pkg;

    localparam int COLOR_W = 3;
    localparam int COORD_W = 8;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_PLOT      = 2'b01,
        OP_FILL_RECT = 2'b10,
        OP_CLEAR     = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DRAW = 2'b10
    } state_t;

    typedef struct packed {
        cmd_op_t              op;
        logic [COORD_W-1:0]   x0;
        logic [COORD_W-1:0]   y0;
        logic [COORD_W-1:0]   x1;
        logic [COORD_W-1:0]   y1;
        logic [COLOR_W-1:0]   color;
    } cmd_t;

    function automatic logic [COORD_W-1:0] clip_coord(input logic [COORD_W-1:0] v,
                                                      input logic [COORD_W-1:0] last);
        return (v > last) ? last : v;
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO: push/pop in one cycle, head word visible combinationally on pop_data.
// Pushes while full and pops while empty are ignored; the caller gates on full/empty.
module gpu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/gpu_draw_sequencer.sv
// Queued PLOT/FILL_RECT/CLEAR rasteriser, one pixel per cycle; first write two cycles after transfer.
// cmd_ready drops only when the queue is full; with GPU_BLANK_WRITE_EN drawing stalls during active video.
module gpu_draw_sequencer
    import gpu_pkg::*;
#(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               pixel_clock,
    input  logic               RESET,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               on_screen,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic [COLOR_W-1:0] fb_color,
    output logic               fb_write,
    output logic               busy,
    output logic               err,
    input  logic               err_clr
);

    localparam logic [COORD_W:0]   FB_W_EXT = (COORD_W+1)'(FB_W);
    localparam logic [COORD_W:0]   FB_H_EXT = (COORD_W+1)'(FB_H);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(FB_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(FB_H - 1);

    state_t state;
    state_t state_nxt;
    cmd_t   in_cmd;
    cmd_t   head_cmd;
    cmd_t   cur_cmd;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic stall;
    logic last_pix;
    logic at_x_end;

    logic [COORD_W-1:0] x_start;
    logic [COORD_W-1:0] x_end;
    logic [COORD_W-1:0] y_end;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic [COLOR_W-1:0] color_q;

    logic [COORD_W-1:0] ld_xs;
    logic [COORD_W-1:0] ld_xe;
    logic [COORD_W-1:0] ld_ys;
    logic [COORD_W-1:0] ld_ye;
    logic [COORD_W-1:0] x1_clip;
    logic [COORD_W-1:0] y1_clip;
    logic               ld_skip;
    logic               ld_oob;

    assign in_cmd = '{op: cmd_op_t'(cmd_op), x0: cmd_x0, y0: cmd_y0,
                      x1: cmd_x1, y1: cmd_y1, color: cmd_color};

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;

    gpu_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (pixel_clock),
        .reset     (RESET),
        .push      (push),
        .push_data (in_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef GPU_BLANK_WRITE_EN
    assign stall = on_screen;
`else
    logic unused_on_screen;
    assign unused_on_screen = on_screen;
    assign stall            = 1'b0;
`endif

    // Bounds for the command held in cur_cmd; ld_skip sends LOAD straight back to IDLE.
    always_comb begin
        x1_clip = clip_coord(cur_cmd.x1, X_LAST);
        y1_clip = clip_coord(cur_cmd.y1, Y_LAST);
        ld_xs   = cur_cmd.x0;
        ld_xe   = cur_cmd.x0;
        ld_ys   = cur_cmd.y0;
        ld_ye   = cur_cmd.y0;
        ld_oob  = 1'b0;
        ld_skip = 1'b1;
        case (cur_cmd.op)
            OP_PLOT: begin
                ld_oob  = ({1'b0, cur_cmd.x0} >= FB_W_EXT) || ({1'b0, cur_cmd.y0} >= FB_H_EXT);
                ld_skip = ld_oob;
            end
            OP_FILL_RECT: begin
                ld_xe   = x1_clip;
                ld_ye   = y1_clip;
                ld_skip = (cur_cmd.x0 > x1_clip) || (cur_cmd.y0 > y1_clip);
            end
            OP_CLEAR: begin
                ld_xs   = '0;
                ld_xe   = X_LAST;
                ld_ys   = '0;
                ld_ye   = Y_LAST;
                ld_skip = 1'b0;
            end
            default: ;
        endcase
    end

    assign at_x_end = (x_cnt == x_end);
    assign last_pix = at_x_end && (y_cnt == y_end);

    always_ff @(posedge pixel_clock) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ld_skip ? ST_IDLE : ST_DRAW;
            ST_DRAW: if (fb_write && last_pix) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop      = (state == ST_IDLE) && !fifo_empty;
        fb_write = (state == ST_DRAW) && !stall;
        busy     = !fifo_empty || (state != ST_IDLE);
    end

    always_ff @(posedge pixel_clock) begin
        if (RESET) begin
            cur_cmd <= '0;
            x_start <= '0;
            x_end   <= '0;
            y_end   <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            color_q <= '0;
            err     <= 1'b0;
        end else begin
            if (pop) cur_cmd <= head_cmd;
            if (state == ST_LOAD) begin
                x_start <= ld_xs;
                x_end   <= ld_xe;
                y_end   <= ld_ye;
                x_cnt   <= ld_xs;
                y_cnt   <= ld_ys;
                color_q <= cur_cmd.color;
            end else if (fb_write && !last_pix) begin
                if (at_x_end) begin
                    x_cnt <= x_start;
                    y_cnt <= y_cnt + 8'd1;
                end else begin
                    x_cnt <= x_cnt + 8'd1;
                end
            end
            // A new error in the same cycle as err_clr wins.
            err <= (err && !err_clr) || ((state == ST_LOAD) && ld_oob);
        end
    end

    assign fb_x     = x_cnt;
    assign fb_y     = y_cnt;
    assign fb_color = color_q;

endmodule

// File: doc/gpu_draw_sequencer.md
GPU_DRAW_SEQUENCER -- requirements
Module: gpu_draw_sequencer

Interface
REQ-001 SHALL have parameter FB_W, default 160, framebuffer width in pixels (max 256).
REQ-002 SHALL have parameter FB_H, default 120, framebuffer height in pixels (max 256).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command queue entries (power of two).
REQ-004 pixel_clock  in  1  sole clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command queue can accept.
REQ-008 cmd_op  in  2  00 NOP, 01 PLOT, 10 FILL_RECT, 11 CLEAR.
REQ-009 cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  8 each  coordinates (x1/y1 used by FILL_RECT only).
REQ-010 cmd_color  in  3  RGB colour.
REQ-011 on_screen  in  1  high during active video.
REQ-012 fb_x, fb_y  out  8 each  framebuffer write address.
REQ-013 fb_color  out  3  framebuffer write data.
REQ-014 fb_write  out  1  one-cycle write strobe per pixel.
REQ-015 busy  out  1  high when queue non-empty or FSM not IDLE.
REQ-016 err  out  1  sticky out-of-bounds PLOT flag.
REQ-017 err_clr  in  1  clears err.

Function
REQ-018 Transfer SHALL occur on each edge where cmd_valid && cmd_ready; cmd_ready SHALL equal queue-not-full, combinationally independent of cmd_valid.
REQ-019 FSM states SHALL be IDLE, LOAD, DRAW; IDLE->LOAD pops queue when non-empty; LOAD->DRAW registers clipped bounds; DRAW->IDLE after last pixel.
REQ-020 With an empty queue and FSM in IDLE, a command transferred at edge k SHALL produce its first fb_write in the cycle following edge k+2.
REQ-021 DRAW SHALL emit at most one pixel per cycle in raster order: x increments first, y increments when x reaches the right bound.
REQ-022 PLOT SHALL write exactly one pixel at (x0,y0); if x0>=FB_W or y0>=FB_H, no write, err set.
REQ-023 FILL_RECT SHALL clip x1 to FB_W-1 and y1 to FB_H-1; if x0>x1 or y0>y1 after clipping, zero writes, no error, return to IDLE.
REQ-024 CLEAR SHALL write cmd_color to all FB_W*FB_H pixels, (0,0) first, (FB_W-1,FB_H-1) last.
REQ-025 NOP SHALL pass through LOAD and return to IDLE with no writes.
REQ-026 fb_x, fb_y, fb_color SHALL be stable and valid whenever fb_write is high.
REQ-027 Push while the FSM pops SHALL be legal when not full; full queue ignores cmd_valid.
REQ-028 err_clr and a simultaneous new error SHALL leave err set.

Reset
REQ-029 RESET SHALL force IDLE, flush the queue, and zero fb_write, fb_x, fb_y, fb_color, busy, err on the next edge.
REQ-030 RESET mid-DRAW SHALL abort the command; no fb_write in the cycle after the reset edge.
REQ-031 cmd_ready SHALL be high in the first cycle after RESET deasserts.

Configuration
REQ-032 Macro GPU_BLANK_WRITE_EN defined: DRAW SHALL stall (counters hold, fb_write low) while on_screen is high, resuming at the same pixel when low.
REQ-033 Macro undefined: on_screen SHALL be ignored and DRAW never stalls.

Structure
REQ-034 Shared package gpu_pkg SHALL hold the cmd_op encodings, FSM state enum, and colour width constant.
REQ-035 Command queue SHALL be sub-module gpu_cmd_fifo (synchronous FIFO, push/pop/full/empty, same reset).

Verification
REQ-036 PLOT (5,7) colour 3 from idle -> single fb_write at (5,7), colour 3, on cycle after edge k+2; busy then low.
REQ-037 FILL_RECT (2,3)-(4,4) colour 6 -> six writes in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), consecutive cycles.
REQ-038 FILL_RECT (150,0)-(200,0), FB_W=160 -> ten writes x=150..159, y=0; err stays low.
REQ-039 PLOT (160,0) then err_clr pulse -> no fb_write, err high until the err_clr edge, then low.
REQ-040 Push 6 commands back-to-back with FIFO_DEPTH=4 while a CLEAR runs -> cmd_ready falls after 4 queued, excess held by source, all 6 execute in order.
REQ-041 RESET asserted mid-CLEAR -> fb_write low on the next cycle, queue empty, busy low; GPU_BLANK_WRITE_EN build: writes occur only where on_screen=0.
